// File: rtl/alu_seq_if.sv
// Request/response bundle between an ALU_SEQ client and the sequential ALU.
// The client side issues operations and accepts results; the ALU side serves them.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [3:0]       select;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] agg;
  logic             V;
  logic             C;
  logic             N;
  logic             Z;
  logic             X;
  logic             set_VC;

  modport master (
    output in_valid, a_in, b_in, select, carry_in, out_ready,
    input  in_ready, out_valid, agg, V, C, N, Z, X, set_VC
  );

  modport slave (
    input  in_valid, a_in, b_in, select, carry_in, out_ready,
    output in_ready, out_valid, agg, V, C, N, Z, X, set_VC
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops, bit-serial shifts and a
// shift-add multiplier, behind a valid/ready request and result handshake.
// Results and flags are held in DONE until the consumer takes them.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);

  // Counter must be able to hold WIDTH itself (MUL and saturated shifts).
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_NOT = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_ADC = 4'd6;
  localparam logic [3:0] OP_SBC = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_ASR = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           next_state;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] agg_q;
  logic             v_q, c_q, n_q, z_q, x_q, vc_q;

  logic             accept;
  logic             is_shift;
  logic             is_mul;
  logic             goes_run;
  logic [SHW-1:0]   shamt;
  logic [CW-1:0]    shamt_sat;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] imm_res;
  logic             imm_c, imm_v, imm_vc;

  logic [WIDTH:0]   madd;
  logic [WIDTH-1:0] step_work;
  logic [WIDTH-1:0] step_lo;
  logic             step_c;
  logic             last_step;

  logic [WIDTH-1:0] fin_res;
  logic             fin_c, fin_v, fin_vc;
  logic             load_result;

  // Decode the incoming request and compute every single-cycle result.
  always_comb begin
    shamt = bus.b_in[SHW-1:0];
    if (32'(shamt) >= 32'(WIDTH)) shamt_sat = CW'(WIDTH);
    else                          shamt_sat = CW'(shamt);

    is_shift = (bus.select == OP_SHL) || (bus.select == OP_SHR) || (bus.select == OP_ASR);
    is_mul   = (bus.select == OP_MUL);
    goes_run = is_mul || (is_shift && (shamt != '0));
    accept   = bus.in_valid && (state == IDLE);

    ext     = '0;
    imm_res = '0;
    imm_c   = 1'b0;
    imm_v   = 1'b0;
    imm_vc  = 1'b1;
    case (bus.select)
      OP_NOT: begin imm_res = ~bus.a_in;            imm_vc = 1'b0; end
      OP_AND: begin imm_res = bus.a_in & bus.b_in;  imm_vc = 1'b0; end
      OP_OR:  begin imm_res = bus.a_in | bus.b_in;  imm_vc = 1'b0; end
      OP_XOR: begin imm_res = bus.a_in ^ bus.b_in;  imm_vc = 1'b0; end
      OP_ADD, OP_ADC: begin
        ext     = {1'b0, bus.a_in} + {1'b0, bus.b_in}
                + {{WIDTH{1'b0}}, (bus.select == OP_ADC) & bus.carry_in};
        imm_res = ext[MSB:0];
        imm_c   = ext[WIDTH];
        imm_v   = (bus.a_in[MSB] == bus.b_in[MSB]) && (bus.a_in[MSB] != ext[MSB]);
      end
      OP_SUB, OP_SBC: begin
        ext     = {1'b0, bus.a_in} - {1'b0, bus.b_in}
                - {{WIDTH{1'b0}}, (bus.select == OP_SBC) & bus.carry_in};
        imm_res = ext[MSB:0];
        imm_c   = ext[WIDTH];
        imm_v   = (bus.a_in[MSB] != bus.b_in[MSB]) && (bus.a_in[MSB] != ext[MSB]);
      end
      OP_SHL, OP_SHR, OP_ASR: imm_res = bus.a_in;
      OP_MUL: imm_res = '0;
      default: begin imm_res = '0; imm_vc = 1'b0; end
    endcase
  end

  // One iteration of the serial shifter or of the shift-add multiplier.
  always_comb begin
    step_work = work_q;
    step_lo   = lo_q;
    step_c    = 1'b0;
    madd      = '0;
    case (op_q)
      OP_SHL: begin step_c = work_q[MSB]; step_work = {work_q[MSB-1:0], 1'b0}; end
      OP_SHR: begin step_c = work_q[0];   step_work = {1'b0, work_q[MSB:1]}; end
      OP_ASR: begin step_c = work_q[0];   step_work = {work_q[MSB], work_q[MSB:1]}; end
      OP_MUL: begin
        madd      = {1'b0, work_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        step_work = madd[WIDTH:1];
        step_lo   = {madd[0], lo_q[MSB:1]};
      end
      default: ;
    endcase
    last_step = (state == RUN) && (cnt_q == CW'(1));
  end

  // Pick the value that lands in the result registers on a finishing edge.
  always_comb begin
    if (state == RUN) begin
      fin_v  = 1'b0;
      fin_vc = 1'b1;
      if (op_q == OP_MUL) begin
        fin_res = step_lo;
        fin_c   = |step_work;
      end else begin
        fin_res = step_work;
        fin_c   = step_c;
      end
    end else begin
      fin_res = imm_res;
      fin_c   = imm_c;
      fin_v   = imm_v;
      fin_vc  = imm_vc;
    end
    load_result = (accept && !goes_run) || last_step;
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: one-cycle ops skip RUN, results wait in DONE for the consumer.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.in_valid) next_state = goes_run ? RUN : DONE;
      RUN:  if (cnt_q == CW'(1)) next_state = DONE;
      DONE: if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, iteration registers and registered result/flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= '0;
      a_q    <= '0;
      work_q <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      agg_q  <= '0;
      v_q    <= 1'b0;
      c_q    <= 1'b0;
      n_q    <= 1'b0;
      z_q    <= 1'b0;
      x_q    <= 1'b0;
      vc_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= bus.select;
        a_q    <= bus.a_in;
        work_q <= is_mul ? '0 : bus.a_in;
        lo_q   <= bus.b_in;
        if (!goes_run)   cnt_q <= '0;
        else if (is_mul) cnt_q <= CW'(WIDTH);
        else             cnt_q <= shamt_sat;
      end else if (state == RUN) begin
        work_q <= step_work;
        lo_q   <= step_lo;
        cnt_q  <= cnt_q - CW'(1);
      end
      if (load_result) begin
        agg_q <= fin_res;
        v_q   <= fin_v;
        c_q   <= fin_c;
        n_q   <= fin_res[MSB];
        z_q   <= (fin_res == '0);
        x_q   <= &fin_res;
        vc_q  <= fin_vc;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.agg       = agg_q;
  assign bus.V         = v_q;
  assign bus.C         = c_q;
  assign bus.N         = n_q;
  assign bus.Z         = z_q;
  assign bus.X         = x_q;
  assign bus.set_VC    = vc_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised, scoreboarded bench for alu_seq at WIDTH=16, with directed
// corner vectors, a held-result scenario and reset-abort scenarios.
module tb_alu_seq;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] agg;
    logic         v, c, n, z, x, vc;
    int           lat;
    int           acc_cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   passed;
  int   ready_mode;
  exp_t sb[$];

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle stamp used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural reference: plain arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] op, input logic cin);
    exp_t        e;
    int          sa, bs, sr, n;
    logic [W:0]  w;
    logic [2*W-1:0] p;
    e.agg = '0; e.v = 1'b0; e.c = 1'b0; e.vc = 1'b1; e.lat = 1; e.acc_cyc = 0;
    sa = int'($signed(a));
    bs = int'($signed(b));
    n  = int'(b[3:0]);
    if (n > W) n = W;
    case (op)
      4'd0: begin e.agg = ~a;    e.vc = 1'b0; end
      4'd1: begin e.agg = a & b; e.vc = 1'b0; end
      4'd2: begin e.agg = a | b; e.vc = 1'b0; end
      4'd3: begin e.agg = a ^ b; e.vc = 1'b0; end
      4'd4, 4'd6: begin
        w = 17'(a) + 17'(b) + ((op == 4'd6) ? 17'(cin) : 17'd0);
        e.agg = w[W-1:0];
        e.c   = w[W];
        sr    = sa + bs + ((op == 4'd6) ? int'(cin) : 0);
        e.v   = (sr > 32767) || (sr < -32768);
      end
      4'd5, 4'd7: begin
        w = 17'(a) - 17'(b) - ((op == 4'd7) ? 17'(cin) : 17'd0);
        e.agg = w[W-1:0];
        e.c   = w[W];
        sr    = sa - bs - ((op == 4'd7) ? int'(cin) : 0);
        e.v   = (sr > 32767) || (sr < -32768);
      end
      4'd8: begin
        e.agg = a << n;
        if (n != 0) begin e.c = a[W-n]; e.lat = n + 1; end
      end
      4'd9: begin
        e.agg = a >> n;
        if (n != 0) begin e.c = a[n-1]; e.lat = n + 1; end
      end
      4'd10: begin
        e.agg = 16'($signed(a) >>> n);
        if (n != 0) begin e.c = a[n-1]; e.lat = n + 1; end
      end
      4'd11: begin
        p     = 32'(a) * 32'(b);
        e.agg = p[W-1:0];
        e.c   = (p[2*W-1:W] != '0);
        e.lat = W + 1;
      end
      default: begin e.agg = '0; e.vc = 1'b0; end
    endcase
    e.n = e.agg[W-1];
    e.z = (e.agg == '0);
    e.x = (e.agg == 16'hFFFF);
    return e;
  endfunction

  function automatic logic [63:0] exp_pack(input exp_t e);
    return 64'({e.agg, e.v, e.c, e.n, e.z, e.x, e.vc});
  endfunction

  function automatic logic [63:0] dut_pack();
    return 64'({bus.agg, bus.V, bus.C, bus.N, bus.Z, bus.X, bus.set_VC});
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Issue one request; the expected response goes into the scoreboard.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [3:0] op, input logic cin);
    exp_t e;
    int   waited;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      checkOutput("accept_timeout", 64'(bus.in_ready), 64'd1);
      return;
    end
    e = model(a, b, op, cin);
    e.acc_cyc = cyc;
    sb.push_back(e);
    bus.a_in     = a;
    bus.b_in     = b;
    bus.select   = op;
    bus.carry_in = cin;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Consumer-side ready: random, always on, or held off.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = ($urandom_range(0, 3) != 0);
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: latency on the first valid cycle, result on the handshake.
  initial begin
    bit   seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        seen = 1'b0;
      end else if (bus.out_valid) begin
        if (sb.size() == 0) begin
          if (!seen) checkOutput("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
          seen = !bus.out_ready;
        end else begin
          e = sb[0];
          if (!seen) begin
            checkOutput("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
            seen = 1'b1;
          end
          if (bus.out_ready) begin
            checkOutput("result", dut_pack(), exp_pack(e));
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    exp_t hold_e;
    logic [W-1:0] ra, rb;
    logic [3:0]   rop;
    cyc = 0; total = 0; passed = 0; ready_mode = 1;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.select = '0; bus.carry_in = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_regs", dut_pack(), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);

    $display("[TB] directed vectors");
    applyStimulus(16'h7FFF, 16'h0001, 4'd4, 1'b0);
    applyStimulus(16'h0000, 16'h0001, 4'd5, 1'b0);
    applyStimulus(16'h0005, 16'h0002, 4'd7, 1'b1);
    applyStimulus(16'h7FFF, 16'h0000, 4'd6, 1'b1);
    applyStimulus(16'h8001, 16'h0003, 4'd8, 1'b0);
    applyStimulus(16'h8000, 16'h000F, 4'd10, 1'b0);
    applyStimulus(16'hABCD, 16'h0010, 4'd9, 1'b0);
    applyStimulus(16'h0100, 16'h0100, 4'd11, 1'b0);
    applyStimulus(16'h0003, 16'h0005, 4'd11, 1'b0);
    applyStimulus(16'h1234, 16'hFFFF, 4'd13, 1'b1);
    applyStimulus(16'h00FF, 16'h0F0F, 4'd0, 1'b0);
    drain();

    $display("[TB] held result");
    ready_mode = 2;
    hold_e = model(16'h1111, 16'h2222, 4'd4, 1'b0);
    applyStimulus(16'h1111, 16'h2222, 4'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_out_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("hold_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("hold_result", dut_pack(), exp_pack(hold_e));
      bus.a_in = 16'hDEAD; bus.b_in = 16'hBEEF; bus.select = 4'd1; bus.in_valid = 1'b1;
    end
    bus.in_valid = 1'b0;
    ready_mode = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("release_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("release_out_valid", 64'(bus.out_valid), 64'd0);
    drain();

    $display("[TB] reset during MUL");
    applyStimulus(16'h1234, 16'h0056, 4'd11, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("abort_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("abort_agg", 64'(bus.agg), 64'd0);

    $display("[TB] request together with reset");
    reset = 1'b1;
    bus.a_in = 16'h0001; bus.b_in = 16'h0001; bus.select = 4'd4; bus.in_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("reset_req_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset_req_out_valid", 64'(bus.out_valid), 64'd0);
    applyStimulus(16'h0002, 16'h0003, 4'd4, 1'b0);
    drain();

    $display("[TB] random traffic");
    ready_mode = 0;
    for (int i = 0; i < 80; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 16'h7FFF;
        1: ra = 16'h8000;
        2: rb = 16'hFFFF;
        default: ;
      endcase
      applyStimulus(ra, rb, rop, 1'($urandom_range(0, 1)));
    end
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
